branch_target_buffer: RTL

//  Direct-mapped branch target buffer with a 2-bit saturating predictor per entry.

---
 rtl/branch_target_buffer.sv | 108 ++++++++++
 1 files changed

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with a 2-bit saturating predictor per entry.
// Lookup is combinational on the fetch PC; training is registered from EX/MEM.
module branch_target_buffer #(
  parameter int WORD_W = 16,
  parameter int IDX_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WORD_W-1:0] pc,
  input  logic              lookup_en,
  output logic [WORD_W-1:0] predicted_pc,
  output logic              predict_taken,
  output logic              btb_hit,
  output logic              no_btb,
  input  logic              update_en,
  input  logic [WORD_W-1:0] update_pc,
  input  logic [WORD_W-1:0] update_target,
  input  logic              update_taken,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  alloc_count
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = WORD_W - IDX_W;

  logic [ENTRIES-1:0]             valid_q, valid_d;
  logic [ENTRIES-1:0][TAG_W-1:0]  tag_q, tag_d;
  logic [ENTRIES-1:0][WORD_W-1:0] target_q, target_d;
  logic [ENTRIES-1:0][1:0]        ctr_q, ctr_d;
  logic [CNT_W-1:0]               hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]               alloc_cnt_q, alloc_cnt_d;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             up_match;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  assign lk_idx = pc[IDX_W-1:0];
  assign lk_tag = pc[WORD_W-1:IDX_W];
  assign up_idx = update_pc[IDX_W-1:0];
  assign up_tag = update_pc[WORD_W-1:IDX_W];

  // Lookup sees the registered state only, so a same-cycle update shows up next cycle.
  assign btb_hit       = reset_n & valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
  assign no_btb        = ~btb_hit;
  assign predict_taken = btb_hit & ctr_q[lk_idx][1];
  assign predicted_pc  = predict_taken ? target_q[lk_idx] : pc + WORD_W'(1);
  assign up_match      = valid_q[up_idx] & (tag_q[up_idx] == up_tag);

  assign hit_count   = hit_cnt_q;
  assign alloc_count = alloc_cnt_q;

  always_comb begin
    valid_d     = valid_q;
    tag_d       = tag_q;
    target_d    = target_q;
    ctr_d       = ctr_q;
    alloc_cnt_d = alloc_cnt_q;
    hit_cnt_d   = hit_cnt_q;
    if (lookup_en && btb_hit) begin
      hit_cnt_d = hit_cnt_q + CNT_W'(1);
    end
    if (update_en) begin
      if (up_match) begin
        if (update_taken) begin
          ctr_d[up_idx]    = sat_inc(ctr_q[up_idx]);
          target_d[up_idx] = update_target;
        end else begin
          ctr_d[up_idx] = sat_dec(ctr_q[up_idx]);
        end
      end else if (update_taken) begin
        // Allocation evicts whatever other tag occupied the slot.
        valid_d[up_idx]  = 1'b1;
        tag_d[up_idx]    = up_tag;
        target_d[up_idx] = update_target;
        ctr_d[up_idx]    = 2'b10;
        alloc_cnt_d      = alloc_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q     <= '0;
      tag_q       <= '0;
      target_q    <= '0;
      ctr_q       <= {ENTRIES{2'b01}};
      hit_cnt_q   <= '0;
      alloc_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      tag_q       <= tag_d;
      target_q    <= target_d;
      ctr_q       <= ctr_d;
      hit_cnt_q   <= hit_cnt_d;
      alloc_cnt_q <= alloc_cnt_d;
    end
  end

endmodule
